univ_shift_reg: RTL

Parametrised universal shift register, successor to the 4-bit left/right serial shifter. Supports hold, shift, rotate, arithmetic shift, parallel load and clear, in single-step or multi-cycle burst mode. A burst runs a programmed number of shifts under a start/busy/done handshake. Used as a serialiser/deserialiser and barrel-shift helper in datapath blocks.

---
 rtl/univ_shift_reg.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//   Parametrised universal shift register. One operation per cycle (hold,
//   SHL, SHR, LOAD, ROL, ROR, ASR, CLR) in single-step mode, or a burst of
//   i_shamt shifts of a captured mode under a start/busy/done handshake.
//
// Parameters
//   WIDTH  register width (>= 2)
//   CNT_W  width of the burst shift count
//
// Ports
//   i_clk     rising-edge clock
//   i_rst     asynchronous active-low reset
//   i_en      single-step enable (idle only)
//   i_mode    operation select
//   i_sin_l   serial in at the MSB end (right shifts)
//   i_sin_r   serial in at the LSB end (left shifts)
//   i_pload   parallel load data
//   i_start   burst request
//   i_shamt   burst shift count
//   o_q       register contents
//   o_sout_l  q[WIDTH-1]
//   o_sout_r  q[0]
//   o_busy    burst in progress
//   o_done    one-cycle pulse at burst end
//   o_parity  registered even parity of q (only with SHREG_PARITY_EN)
//
// Optional feature macro: SHREG_PARITY_EN
// -----------------------------------------------------------------------------
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [2:0]       i_mode,
   input  logic             i_sin_l,
   input  logic             i_sin_r,
   input  logic [WIDTH-1:0] i_pload,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_shamt,
   output logic [WIDTH-1:0] o_q,
   output logic             o_sout_l,
   output logic             o_sout_r,
   output logic             o_busy,
`ifdef SHREG_PARITY_EN
   output logic             o_parity,
`endif
   output logic             o_done
);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHL  = 3'b001;
   localparam logic [2:0] M_SHR  = 3'b010;
   localparam logic [2:0] M_LOAD = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ROR  = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;
   localparam logic [2:0] M_CLR  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_mode;
   logic [WIDTH-1:0] r_q;
   logic             r_busy;
   logic             r_done;

   logic [2:0]       w_step_mode;
   logic             w_apply;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_shift_cls;

   // Only the shift-class modes make a burst do anything; load/clear/hold
   // bursts complete immediately without touching q.
   assign w_shift_cls = (i_mode == M_SHL) || (i_mode == M_SHR) ||
                        (i_mode == M_ROL) || (i_mode == M_ROR) ||
                        (i_mode == M_ASR);

   // Next-q datapath, shared by single-step and burst so parity can be
   // registered from the same value on the same edge.
   always_comb begin
      w_apply     = 1'b0;
      w_step_mode = r_mode;
      w_q_nxt     = r_q;
      case (r_state)
         IDLE: begin
            // start wins over en; the start edge itself leaves q alone
            if (!i_start && i_en) begin
               w_apply     = 1'b1;
               w_step_mode = i_mode;
            end
         end
         RUN:     w_apply = 1'b1;
         default: w_apply = 1'b0;
      endcase
      if (w_apply) begin
         case (w_step_mode)
            M_HOLD:  w_q_nxt = r_q;
            M_SHL:   w_q_nxt = {r_q[WIDTH-2:0], i_sin_r};
            M_SHR:   w_q_nxt = {i_sin_l, r_q[WIDTH-1:1]};
            M_LOAD:  w_q_nxt = i_pload;
            M_ROL:   w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            M_ROR:   w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
            M_ASR:   w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            M_CLR:   w_q_nxt = '0;
            default: w_q_nxt = r_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_mode  <= M_HOLD;
         r_q     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_q <= w_q_nxt;
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_mode <= i_mode;
                  r_cnt  <= i_shamt;
                  if (w_shift_cls && (i_shamt != '0)) begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= FIN;
                     r_done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= FIN;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            FIN: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SHREG_PARITY_EN
   logic r_parity;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_parity <= 1'b0;
      else        r_parity <= ^w_q_nxt;
   end

   assign o_parity = r_parity;
`endif

   assign o_q      = r_q;
   assign o_sout_l = r_q[WIDTH-1];
   assign o_sout_r = r_q[0];
   assign o_busy   = r_busy;
   assign o_done   = r_done;

endmodule
